// File: rtl/mbist_data_cmp_lane.sv
// mbist_data_cmp_lane
// Compares MBIST read data against the expected pattern lane by lane.
// Repairable failures are counted up to BIST_ERR_LIMIT. Each counted failure
// (address plus failing-lane mask) goes into a small failure-log FIFO that
// the repair logic drains after the march.
// Optional feature macro: BIST_LANE_MASK_EN. It adds a lane_en input, and a
// disabled lane can never report a miss.
module mbist_data_cmp_lane #(
  parameter int BIST_ADDR_WD   = 9,
  parameter int BIST_DATA_WD   = 32,
  parameter int BIST_LANE_WD   = 8,
  parameter int BIST_ERR_LIMIT = 4,
  parameter int BIST_CNT_WD    = 4,
  parameter int BIST_LOG_DEPTH = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   clear,
  input  logic                                   compare,
  input  logic                                   addr_inc_phase,
  input  logic                                   read_invert,
  input  logic [BIST_DATA_WD-1:0]                comp_data,
  input  logic [BIST_DATA_WD-1:0]                rxd_data,
  input  logic [BIST_ADDR_WD-1:0]                addr,
  input  logic                                   log_rd,
`ifdef BIST_LANE_MASK_EN
  input  logic [BIST_DATA_WD/BIST_LANE_WD-1:0]   lane_en,
`endif
  output logic                                   error,
  output logic                                   error_correct,
  output logic                                   correct,
  output logic [BIST_CNT_WD-1:0]                 error_cnt,
  output logic [BIST_ADDR_WD-1:0]                error_addr,
  output logic [BIST_DATA_WD/BIST_LANE_WD-1:0]   lane_fail,
  output logic                                   log_valid,
  output logic [BIST_ADDR_WD-1:0]                log_addr,
  output logic [BIST_DATA_WD/BIST_LANE_WD-1:0]   log_lane,
  output logic                                   log_full,
  output logic                                   log_ovf
);

  localparam int LANES = BIST_DATA_WD / BIST_LANE_WD;
  localparam int PW    = (BIST_LOG_DEPTH > 1) ? $clog2(BIST_LOG_DEPTH) : 1;

  localparam logic [BIST_CNT_WD-1:0] LIMIT_C   = BIST_ERR_LIMIT[BIST_CNT_WD-1:0];
  localparam logic [BIST_CNT_WD-1:0] CNT_ONE_C = {{(BIST_CNT_WD-1){1'b0}}, 1'b1};
  localparam logic [PW:0]            DEPTH_C   = BIST_LOG_DEPTH[PW:0];
  localparam logic [PW:0]            OCC_ONE_C = {{PW{1'b0}}, 1'b1};
  localparam logic [PW-1:0]          PTR_ONE_C = {{(PW-1){1'b0}}, 1'b1};

  // Returns one bit per lane, set when any bit of that lane differs.
  function automatic logic [LANES-1:0] lane_diff(
    input logic [BIST_DATA_WD-1:0] exp_word,
    input logic [BIST_DATA_WD-1:0] rd_word
  );
    logic [BIST_DATA_WD-1:0] x;
    logic [LANES-1:0]        res;
    x = exp_word ^ rd_word;
    for (int i = 0; i < LANES; i++) begin
      res[i] = |x[i*BIST_LANE_WD +: BIST_LANE_WD];
    end
    return res;
  endfunction

  // Stage-1 registers
  logic                    cmp_hit_r;
  logic [LANES-1:0]        lane_miss_r;
  logic [BIST_ADDR_WD-1:0] error_addr_r;

  // Stage-2 registers
  logic                    mask_r;
  logic [BIST_CNT_WD-1:0]  error_cnt_r;
  logic                    correct_r;
  logic [LANES-1:0]        lane_fail_r;

  // Failure log storage
  logic [BIST_ADDR_WD-1:0] log_mem_addr_r [BIST_LOG_DEPTH];
  logic [LANES-1:0]        log_mem_lane_r [BIST_LOG_DEPTH];
  logic [PW-1:0]           wr_ptr_r;
  logic [PW-1:0]           rd_ptr_r;
  logic [PW:0]             log_occ_r;
  logic                    log_ovf_r;

  // Combinational control
  logic [BIST_DATA_WD-1:0] exp_data_s;
  logic [LANES-1:0]        lane_miss_next_s;
  logic                    cmp_take_s;
  logic                    mask_release_s;
  logic                    error_correct_s;
  logic                    log_full_s;
  logic                    log_pop_s;
  logic                    log_push_s;
  logic                    log_drop_s;

  // Expected word, per-lane miss vector and the stage-2 / log handshakes.
  always_comb begin
    exp_data_s       = '0;
    lane_miss_next_s = '0;
    if (read_invert) begin
      exp_data_s = ~comp_data;
    end else begin
      exp_data_s = comp_data;
    end
`ifdef BIST_LANE_MASK_EN
    lane_miss_next_s = lane_diff(exp_data_s, rxd_data) & lane_en;
`else
    lane_miss_next_s = lane_diff(exp_data_s, rxd_data);
`endif
    // A compare one cycle after a failing one is suppressed by cmp_hit_r.
    cmp_take_s      = compare && !mask_r && !cmp_hit_r;
    // The mask release wins over any hit that is pending in the same cycle.
    mask_release_s  = mask_r && addr_inc_phase;
    error_correct_s = cmp_hit_r && (error_cnt_r < LIMIT_C) && !mask_release_s;
    log_full_s      = (log_occ_r == DEPTH_C);
    log_pop_s       = log_rd && (log_occ_r != '0);
    // A full log still accepts a push when a pop frees a slot in the same cycle.
    log_push_s      = error_correct_s && (!log_full_s || log_pop_s);
    log_drop_s      = error_correct_s && log_full_s && !log_pop_s;
  end

  // Stage 1: capture the lane miss vector and address of an unmasked compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_hit_r    <= 1'b0;
      lane_miss_r  <= '0;
      error_addr_r <= '0;
    end else if (clear) begin
      cmp_hit_r    <= 1'b0;
      lane_miss_r  <= '0;
      error_addr_r <= '0;
    end else if (cmp_take_s) begin
      cmp_hit_r    <= |lane_miss_next_s;
      lane_miss_r  <= lane_miss_next_s;
      error_addr_r <= addr;
    end else begin
      cmp_hit_r    <= 1'b0;
      lane_miss_r  <= '0;
    end
  end

  // Stage 2: count the failure, mask the address, accumulate sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_r      <= 1'b0;
      error_cnt_r <= '0;
      correct_r   <= 1'b0;
      lane_fail_r <= '0;
    end else if (clear) begin
      mask_r      <= 1'b0;
      error_cnt_r <= '0;
      correct_r   <= 1'b0;
      lane_fail_r <= '0;
    end else begin
      if (mask_release_s) begin
        mask_r <= 1'b0;
      end else if (error_correct_s) begin
        mask_r <= 1'b1;
      end else begin
        mask_r <= mask_r;
      end
      // error_correct_s already guarantees error_cnt_r is below the limit.
      if (error_correct_s) begin
        error_cnt_r <= error_cnt_r + CNT_ONE_C;
        correct_r   <= 1'b1;
        lane_fail_r <= lane_fail_r | lane_miss_r;
      end
    end
  end

  // Failure log: write the stage-1 address/mask on each counted failure, pop on log_rd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BIST_LOG_DEPTH; i++) begin
        log_mem_addr_r[i] <= '0;
        log_mem_lane_r[i] <= '0;
      end
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      log_occ_r <= '0;
      log_ovf_r <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < BIST_LOG_DEPTH; i++) begin
        log_mem_addr_r[i] <= '0;
        log_mem_lane_r[i] <= '0;
      end
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      log_occ_r <= '0;
      log_ovf_r <= 1'b0;
    end else begin
      if (log_push_s) begin
        log_mem_addr_r[wr_ptr_r] <= error_addr_r;
        log_mem_lane_r[wr_ptr_r] <= lane_miss_r;
        wr_ptr_r                 <= wr_ptr_r + PTR_ONE_C;
      end
      if (log_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      case ({log_push_s, log_pop_s})
        2'b10:   log_occ_r <= log_occ_r + OCC_ONE_C;
        2'b01:   log_occ_r <= log_occ_r - OCC_ONE_C;
        default: log_occ_r <= log_occ_r;
      endcase
      if (log_drop_s) begin
        log_ovf_r <= 1'b1;
      end
    end
  end

  assign error_correct = error_correct_s;
  assign error         = (error_cnt_r >= LIMIT_C);
  assign correct       = correct_r;
  assign error_cnt     = error_cnt_r;
  assign error_addr    = error_addr_r;
  assign lane_fail     = lane_fail_r;
  assign log_valid     = (log_occ_r != '0);
  assign log_full      = log_full_s;
  assign log_ovf       = log_ovf_r;
  assign log_addr      = log_mem_addr_r[rd_ptr_r];
  assign log_lane      = log_mem_lane_r[rd_ptr_r];

endmodule

// File: tb/tb_mbist_data_cmp_lane.sv
// Bench for mbist_data_cmp_lane. It drives a table of directed vectors, then
// randomized traffic against a queue-based reference model. A second
// instance with a 2-entry log covers the overflow path.
module tb_mbist_data_cmp_lane;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int LANES = 4;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, clear, compare, addr_inc_phase, read_invert, log_rd;
  logic [DW-1:0]   comp_data, rxd_data;
  logic [AW-1:0]   addr;
  logic [LANES-1:0] lane_en;

  logic            error, error_correct, correct, log_valid, log_full, log_ovf;
  logic [3:0]      error_cnt;
  logic [AW-1:0]   error_addr, log_addr;
  logic [LANES-1:0] lane_fail, log_lane;

  logic            b_error, b_error_correct, b_correct, b_log_valid, b_log_full, b_log_ovf;
  logic [3:0]      b_error_cnt;
  logic [AW-1:0]   b_error_addr, b_log_addr;
  logic [LANES-1:0] b_lane_fail, b_log_lane;

  mbist_data_cmp_lane dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .compare(compare),
    .addr_inc_phase(addr_inc_phase), .read_invert(read_invert),
    .comp_data(comp_data), .rxd_data(rxd_data), .addr(addr), .log_rd(log_rd),
`ifdef BIST_LANE_MASK_EN
    .lane_en(lane_en),
`endif
    .error(error), .error_correct(error_correct), .correct(correct),
    .error_cnt(error_cnt), .error_addr(error_addr), .lane_fail(lane_fail),
    .log_valid(log_valid), .log_addr(log_addr), .log_lane(log_lane),
    .log_full(log_full), .log_ovf(log_ovf)
  );

  mbist_data_cmp_lane #(.BIST_LOG_DEPTH(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .clear(clear), .compare(compare),
    .addr_inc_phase(addr_inc_phase), .read_invert(read_invert),
    .comp_data(comp_data), .rxd_data(rxd_data), .addr(addr), .log_rd(log_rd),
`ifdef BIST_LANE_MASK_EN
    .lane_en(lane_en),
`endif
    .error(b_error), .error_correct(b_error_correct), .correct(b_correct),
    .error_cnt(b_error_cnt), .error_addr(b_error_addr), .lane_fail(b_lane_fail),
    .log_valid(b_log_valid), .log_addr(b_log_addr), .log_lane(b_log_lane),
    .log_full(b_log_full), .log_ovf(b_log_ovf)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  typedef struct { bit [8:0] a; bit [3:0] l; } ent_t;
  ent_t     q_big[$];
  ent_t     q_small[$];
  bit       m_hit, m_mask, m_correct, m_ovf_big, m_ovf_small;
  bit [3:0] m_miss, m_lf;
  bit [8:0] m_eaddr;
  int       m_cnt;
  logic     last_ec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hit = 1'b0; m_mask = 1'b0; m_correct = 1'b0; m_ovf_big = 1'b0; m_ovf_small = 1'b0;
    m_miss = 4'd0; m_lf = 4'd0; m_eaddr = 9'd0; m_cnt = 0;
    q_big.delete();
    q_small.delete();
  endtask

  task automatic check_outputs();
    chk("error_cnt", 32'(error_cnt), 32'(m_cnt));
    chk("error", 32'(error), 32'(m_cnt >= LIMIT));
    chk("correct", 32'(correct), 32'(m_correct));
    chk("error_addr", 32'(error_addr), 32'(m_eaddr));
    chk("lane_fail", 32'(lane_fail), 32'(m_lf));
    chk("log_valid", 32'(log_valid), 32'(q_big.size() > 0));
    chk("log_full", 32'(log_full), 32'(q_big.size() == 4));
    chk("log_ovf", 32'(log_ovf), 32'(m_ovf_big));
    if (q_big.size() > 0) begin
      chk("log_addr", 32'(log_addr), 32'(q_big[0].a));
      chk("log_lane", 32'(log_lane), 32'(q_big[0].l));
    end
    chk("small_log_valid", 32'(b_log_valid), 32'(q_small.size() > 0));
    chk("small_log_full", 32'(b_log_full), 32'(q_small.size() == 2));
    chk("small_log_ovf", 32'(b_log_ovf), 32'(m_ovf_small));
    if (q_small.size() > 0) begin
      chk("small_log_addr", 32'(b_log_addr), 32'(q_small[0].a));
      chk("small_log_lane", 32'(b_log_lane), 32'(q_small[0].l));
    end
  endtask

  // One clock: check the combinational report, advance the model, check state.
  task automatic cycle_check();
    bit        ec, pop_b, pop_s, new_mask;
    bit [31:0] diff, expw;
    bit [3:0]  nm;
    ent_t      e;
    #3;
    ec = m_hit && (m_cnt < LIMIT) && !(m_mask && addr_inc_phase);
    last_ec = error_correct;
    chk("error_correct", 32'(error_correct), 32'(ec));
    @(posedge clk);
    if (clear) begin
      model_reset();
    end else begin
      e = '{a: m_eaddr, l: m_miss};
      pop_b = log_rd && (q_big.size() > 0);
      pop_s = log_rd && (q_small.size() > 0);
      if (pop_b) void'(q_big.pop_front());
      if (pop_s) void'(q_small.pop_front());
      if (ec) begin
        if (q_big.size() < 4) q_big.push_back(e); else m_ovf_big = 1'b1;
        if (q_small.size() < 2) q_small.push_back(e); else m_ovf_small = 1'b1;
        m_cnt++;
        m_correct = 1'b1;
        m_lf = m_lf | m_miss;
      end
      new_mask = (m_mask && addr_inc_phase) ? 1'b0 : (ec ? 1'b1 : m_mask);
      if (compare && !m_mask && !m_hit) begin
        expw = read_invert ? ~comp_data : comp_data;
        diff = expw ^ rxd_data;
        for (int i = 0; i < LANES; i++) nm[i] = (((diff >> (8 * i)) & 32'hFF) != 32'd0);
        m_miss = nm;
        m_hit = (nm != 4'd0);
        m_eaddr = addr;
      end else begin
        m_hit = 1'b0;
        m_miss = 4'd0;
      end
      m_mask = new_mask;
    end
    #1;
    check_outputs();
  endtask

  typedef struct {
    logic        cmp, aip, inv, rd, clr;
    logic [8:0]  a;
    logic [31:0] flip;
    logic        exp_ec;
    int          exp_cnt;
    logic        exp_lv;
  } vec_t;

  vec_t        tv[24];
  logic [8:0]  head_a[4];
  logic [3:0]  head_l[4];

  initial begin
    // cmp aip inv rd clr addr flip ec cnt lv
    tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h005, 32'h0000_0100, 1'b0, 0, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h005, 32'h0000_0100, 1'b1, 1, 1'b1};
    tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h005, 32'h0000_0100, 1'b0, 1, 1'b1};
    tv[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0000_0000, 1'b0, 1, 1'b1};
    tv[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h006, 32'h0000_0001, 1'b0, 1, 1'b1};
    tv[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0000_0000, 1'b1, 2, 1'b1};
    tv[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0000_0000, 1'b0, 2, 1'b1};
    tv[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h007, 32'h8000_0000, 1'b0, 2, 1'b1};
    tv[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0000_0000, 1'b1, 3, 1'b1};
    tv[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0000_0000, 1'b0, 3, 1'b1};
    tv[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h008, 32'h0001_0200, 1'b0, 3, 1'b1};
    tv[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0000_0000, 1'b1, 4, 1'b1};
    tv[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0000_0000, 1'b0, 4, 1'b1};
    tv[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h009, 32'h0000_0004, 1'b0, 4, 1'b1};
    tv[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0000_0000, 1'b0, 4, 1'b1};
    tv[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0000_0000, 1'b0, 4, 1'b1};
    tv[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 32'h0000_0000, 1'b0, 4, 1'b1};
    tv[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 32'h0000_0000, 1'b0, 4, 1'b1};
    tv[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 32'h0000_0000, 1'b0, 4, 1'b1};
    tv[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 32'h0000_0000, 1'b0, 4, 1'b0};
    tv[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 32'h0000_0000, 1'b0, 0, 1'b0};
    tv[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h003, 32'h0001_0000, 1'b0, 0, 1'b0};
    tv[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 32'h0000_0000, 1'b1, 0, 1'b0};
    tv[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0000_0000, 1'b0, 0, 1'b0};
    head_a[0] = 9'h005; head_l[0] = 4'b0010;
    head_a[1] = 9'h006; head_l[1] = 4'b0001;
    head_a[2] = 9'h007; head_l[2] = 4'b1000;
    head_a[3] = 9'h008; head_l[3] = 4'b0110;

    rst_n = 1'b0; clear = 1'b0; compare = 1'b0; addr_inc_phase = 1'b0;
    read_invert = 1'b0; log_rd = 1'b0; comp_data = '0; rxd_data = '0;
    addr = '0; lane_en = '1;
    model_reset();
    #12;
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_error_cnt", 32'(error_cnt), 32'd0);
    chk("rst_correct", 32'(correct), 32'd0);
    chk("rst_log_valid", 32'(log_valid), 32'd0);
    chk("rst_log_addr", 32'(log_addr), 32'd0);
    chk("rst_log_lane", 32'(log_lane), 32'd0);
    chk("rst_lane_fail", 32'(lane_fail), 32'd0);
    chk("rst_log_ovf", 32'(log_ovf), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Clean march with alternating data polarity
    for (int i = 0; i < 16; i++) begin
      compare = 1'b1;
      read_invert = i[0];
      addr = 9'(i);
      comp_data = $urandom;
      rxd_data = read_invert ? ~comp_data : comp_data;
      cycle_check();
    end
    compare = 1'b0;
    cycle_check();
    cycle_check();
    chk("clean_error_cnt", 32'(error_cnt), 32'd0);
    chk("clean_correct", 32'(correct), 32'd0);
    chk("clean_log_valid", 32'(log_valid), 32'd0);

    // Directed vector table
    for (int i = 0; i < 24; i++) begin
      compare = tv[i].cmp;
      addr_inc_phase = tv[i].aip;
      read_invert = tv[i].inv;
      log_rd = tv[i].rd;
      clear = tv[i].clr;
      addr = tv[i].a;
      comp_data = 32'h5A5A_0000 ^ 32'(i);
      rxd_data = (tv[i].inv ? ~comp_data : comp_data) ^ tv[i].flip;
      if (i >= 16 && i <= 19) begin
        chk("tab_pop_head_addr", 32'(log_addr), 32'(head_a[i-16]));
        chk("tab_pop_head_lane", 32'(log_lane), 32'(head_l[i-16]));
      end
      cycle_check();
      chk("tab_ec", 32'(last_ec), 32'(tv[i].exp_ec));
      chk("tab_cnt", 32'(error_cnt), 32'(tv[i].exp_cnt));
      chk("tab_lv", 32'(log_valid), 32'(tv[i].exp_lv));
      if (i == 0) chk("tab_err_addr", 32'(error_addr), 32'h005);
      if (i == 1) begin
        chk("tab_first_lane_fail", 32'(lane_fail), 32'b0010);
        chk("tab_first_head_addr", 32'(log_addr), 32'h005);
        chk("tab_first_head_lane", 32'(log_lane), 32'b0010);
      end
      if (i == 15) begin
        chk("tab_limit_error", 32'(error), 32'd1);
        chk("tab_limit_full", 32'(log_full), 32'd1);
        chk("tab_limit_ovf", 32'(log_ovf), 32'd0);
        chk("tab_limit_lane_fail", 32'(lane_fail), 32'b1111);
        chk("tab_small_full", 32'(b_log_full), 32'd1);
        chk("tab_small_ovf", 32'(b_log_ovf), 32'd1);
      end
      if (i == 22) chk("tab_clear_correct", 32'(correct), 32'd0);
    end
    clear = 1'b0;
    log_rd = 1'b0;

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      compare = ($urandom_range(3) != 0);
      addr_inc_phase = ($urandom_range(2) == 0);
      read_invert = $urandom_range(1) != 0;
      log_rd = ($urandom_range(3) == 0);
      clear = ($urandom_range(59) == 0);
      addr = 9'($urandom);
      comp_data = $urandom;
      rxd_data = read_invert ? ~comp_data : comp_data;
      if ($urandom_range(2) == 0) rxd_data = rxd_data ^ (32'd1 << $urandom_range(31));
      if ($urandom_range(7) == 0) rxd_data = rxd_data ^ $urandom;
      cycle_check();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
